// File: rtl/video_cfg_ctl.sv
// video_cfg_ctl: shadow/live configuration registers for video_sync with frame-boundary commit and 50/60Hz settle.
// Optional readback mux enabled by defining VCFG_RDBK_EN.
module video_cfg_ctl #(
    parameter int unsigned SETTLE_FRAMES = 2,
    parameter logic [4:0]  GO_OFFS_RST   = 5'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c3,
    input  logic       frame_start,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [8:0] hpix_beg,
    output logic [8:0] hpix_end,
    output logic [8:0] vpix_beg,
    output logic [8:0] vpix_end,
    output logic [4:0] go_offs,
    output logic [1:0] x_offs,
    output logic [7:0] cstart,
    output logic [8:0] rstart,
    output logic [7:0] hint_beg,
    output logic [8:0] vint_beg,
    output logic       cfg_60hz,
    output logic       nogfx,
    output logic       y_offs_wr,
    output logic       cfg_pend,
    input  logic [2:0] rd_addr,
    output logic [7:0] rd_data
);
    typedef enum logic [1:0] {IDLE, PEND, SETTLE} state_t;
    state_t state, state_nx;
    logic [1:0] sh_rres, sh_xoffs;
    logic       sh_60, sh_nogfx, live_nogfx, dirty;
    logic [4:0] sh_go;
    logic [7:0] sh_cstart;
    logic [3:0] settle_cnt;
    logic       commit, wr_grp, toggle, do_copy, last;
    logic [8:0] hb, he, vb, ve;

    assign commit   = frame_start && c3;
    assign wr_grp   = wr_en && (wr_addr == 3'd0 || wr_addr == 3'd1 || wr_addr == 3'd4);
    assign toggle   = sh_60 != cfg_60hz;
    assign do_copy  = commit && (state == PEND || (state == SETTLE && dirty));
    assign last     = commit && state == SETTLE && !(dirty && toggle) && settle_cnt == 4'd1;
    assign nogfx    = live_nogfx || state == SETTLE;
    assign cfg_pend = dirty;

    assign hb = sh_rres == 2'd0 ? 9'd140 : sh_rres == 2'd3 ? 9'd88 : 9'd108;
    assign he = sh_rres == 2'd0 ? 9'd396 : sh_rres == 2'd3 ? 9'd448 : 9'd428;
    assign vb = sh_rres == 2'd0 ? 9'd80 : sh_rres == 2'd1 ? 9'd76 : sh_rres == 2'd2 ? 9'd56 : 9'd32;
    assign ve = sh_rres == 2'd0 ? 9'd272 : sh_rres == 2'd1 ? 9'd276 : sh_rres == 2'd2 ? 9'd296 : 9'd320;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    // a group write landing on the commit clock keeps the FSM pending for the next frame
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = wr_grp ? PEND : IDLE;
            PEND:    state_nx = !commit ? PEND : toggle ? SETTLE : wr_grp ? PEND : IDLE;
            SETTLE:  state_nx = !last ? SETTLE : wr_grp ? PEND : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_rres    <= 2'd0;
            sh_60      <= 1'b0;
            sh_nogfx   <= 1'b0;
            sh_xoffs   <= 2'd0;
            sh_go      <= GO_OFFS_RST;
            sh_cstart  <= 8'd0;
            dirty      <= 1'b0;
            settle_cnt <= 4'd0;
            hpix_beg   <= 9'd140;
            hpix_end   <= 9'd396;
            vpix_beg   <= 9'd80;
            vpix_end   <= 9'd272;
            go_offs    <= GO_OFFS_RST;
            x_offs     <= 2'd0;
            cstart     <= 8'd0;
            cfg_60hz   <= 1'b0;
            live_nogfx <= 1'b0;
            rstart     <= 9'd0;
            hint_beg   <= 8'd2;
            vint_beg   <= 9'd0;
            y_offs_wr  <= 1'b0;
        end else begin
            y_offs_wr <= wr_en && (wr_addr == 3'd2 || wr_addr == 3'd3);
            dirty     <= wr_grp || (dirty && !do_copy);
            if (do_copy) begin
                hpix_beg   <= hb;
                hpix_end   <= he;
                vpix_beg   <= vb;
                vpix_end   <= ve;
                go_offs    <= sh_go;
                x_offs     <= sh_xoffs;
                cstart     <= sh_cstart;
                cfg_60hz   <= sh_60;
                live_nogfx <= sh_nogfx;
            end
            if (do_copy && toggle)
                settle_cnt <= 4'(SETTLE_FRAMES);
            else if (commit && state == SETTLE)
                settle_cnt <= settle_cnt - 4'd1;
            if (wr_en)
                case (wr_addr)
                    3'd0: {sh_nogfx, sh_60, sh_rres} <= wr_data[3:0];
                    3'd1: {sh_go, sh_xoffs} <= wr_data[6:0];
                    3'd2: rstart[7:0] <= wr_data;
                    3'd3: rstart[8] <= wr_data[0];
                    3'd4: sh_cstart <= wr_data;
                    3'd5: hint_beg <= wr_data;
                    3'd6: vint_beg[7:0] <= wr_data;
                    3'd7: vint_beg[8] <= wr_data[0];
                endcase
        end
    end

`ifdef VCFG_RDBK_EN
    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            3'd0:    rd_data = {4'b0, sh_nogfx, sh_60, sh_rres};
            3'd1:    rd_data = {1'b0, sh_go, sh_xoffs};
            3'd2:    rd_data = rstart[7:0];
            3'd3:    rd_data = {7'b0, rstart[8]};
            3'd4:    rd_data = sh_cstart;
            3'd5:    rd_data = hint_beg;
            3'd6:    rd_data = vint_beg[7:0];
            default: rd_data = {7'b0, vint_beg[8]};
        endcase
    end
`else
    logic unused_rd;
    assign unused_rd = ^rd_addr;
    assign rd_data   = 8'h00;
`endif
endmodule

// File: tb/tb_video_cfg_ctl.sv
// tb_video_cfg_ctl: directed and random checks of video_cfg_ctl against a frame-level reference model.
module tb_video_cfg_ctl;
    localparam int SF = 2;
    logic       clk = 1'b0, rst = 1'b1, c3 = 1'b0, frame_start = 1'b0, wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0, rd_addr = 3'd0;
    logic [7:0] wr_data = 8'd0;
    logic [8:0] hpix_beg, hpix_end, vpix_beg, vpix_end, rstart, vint_beg;
    logic [4:0] go_offs;
    logic [1:0] x_offs;
    logic [7:0] cstart, hint_beg, rd_data;
    logic       cfg_60hz, nogfx, y_offs_wr, cfg_pend;

    video_cfg_ctl #(.SETTLE_FRAMES(SF), .GO_OFFS_RST(5'd4)) dut (
        .clk(clk), .rst(rst), .c3(c3), .frame_start(frame_start),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .hpix_beg(hpix_beg), .hpix_end(hpix_end), .vpix_beg(vpix_beg), .vpix_end(vpix_end),
        .go_offs(go_offs), .x_offs(x_offs), .cstart(cstart), .rstart(rstart),
        .hint_beg(hint_beg), .vint_beg(vint_beg), .cfg_60hz(cfg_60hz), .nogfx(nogfx),
        .y_offs_wr(y_offs_wr), .cfg_pend(cfg_pend), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int hb_t[4] = '{140, 108, 108, 88};
    int he_t[4] = '{396, 428, 428, 448};
    int vb_t[4] = '{80, 76, 56, 32};
    int ve_t[4] = '{272, 276, 296, 320};

    // model: shadow and live group bytes, frames of settle remaining, pending flag
    logic [7:0] m_sh0, m_sh1, m_sh4, m_l0, m_l1, m_l4, m_hint;
    logic [8:0] m_rs, m_vint;
    logic       m_dirty, m_ywr;
    int         m_settle;

    task automatic m_reset();
        m_sh0 = 0; m_sh1 = 8'h10; m_sh4 = 0;
        m_l0 = 0; m_l1 = 8'h10; m_l4 = 0;
        m_hint = 8'd2; m_rs = 0; m_vint = 0;
        m_dirty = 0; m_ywr = 0; m_settle = 0;
    endtask

    task automatic m_clock(input logic we, input logic [2:0] a, input logic [7:0] d, input logic cm);
        logic grp;
        grp = we && (a == 0 || a == 1 || a == 4);
        m_ywr = we && (a == 2 || a == 3);
        if (cm) begin
            if (m_dirty) begin
                if (m_sh0[2] != m_l0[2]) m_settle = SF;
                else if (m_settle > 0) m_settle--;
                m_l0 = m_sh0; m_l1 = m_sh1; m_l4 = m_sh4;
            end else if (m_settle > 0) m_settle--;
        end
        m_dirty = grp || (m_dirty && !cm);
        if (we)
            case (a)
                0: m_sh0 = d & 8'h0f;
                1: m_sh1 = d & 8'h7f;
                2: m_rs[7:0] = d;
                3: m_rs[8] = d[0];
                4: m_sh4 = d;
                5: m_hint = d;
                6: m_vint[7:0] = d;
                default: m_vint[8] = d[0];
            endcase
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("hpix_beg", 16'(hpix_beg), 16'(hb_t[m_l0[1:0]]));
        chk("hpix_end", 16'(hpix_end), 16'(he_t[m_l0[1:0]]));
        chk("vpix_beg", 16'(vpix_beg), 16'(vb_t[m_l0[1:0]]));
        chk("vpix_end", 16'(vpix_end), 16'(ve_t[m_l0[1:0]]));
        chk("go_offs", 16'(go_offs), 16'(m_l1[6:2]));
        chk("x_offs", 16'(x_offs), 16'(m_l1[1:0]));
        chk("cstart", 16'(cstart), 16'(m_l4));
        chk("rstart", 16'(rstart), 16'(m_rs));
        chk("hint_beg", 16'(hint_beg), 16'(m_hint));
        chk("vint_beg", 16'(vint_beg), 16'(m_vint));
        chk("cfg_60hz", 16'(cfg_60hz), 16'(m_l0[2]));
        chk("nogfx", 16'(nogfx), 16'(m_l0[3] || m_settle > 0));
        chk("y_offs_wr", 16'(y_offs_wr), 16'(m_ywr));
        chk("cfg_pend", 16'(cfg_pend), 16'(m_dirty));
        chk("rd_data", 16'(rd_data), 16'h0);
    endtask

    task automatic step(input logic r, input logic we, input logic [2:0] a, input logic [7:0] d,
                        input logic fs, input logic c);
        rst = r; wr_en = we; wr_addr = a; wr_data = d; frame_start = fs; c3 = c;
        rd_addr = 3'($urandom);
        @(posedge clk);
        if (r) m_reset();
        else m_clock(we, a, d, fs && c);
        #1;
        check_all();
    endtask

    initial begin
        m_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_hpix_beg", 16'(hpix_beg), 16'd140);
        chk("rst_vpix_end", 16'(vpix_end), 16'd272);
        chk("rst_go_offs", 16'(go_offs), 16'd4);
        chk("rst_hint", 16'(hint_beg), 16'd2);
        // resolution change mid-frame, then frame_start without c3, then real commit
        step(0, 1, 0, 8'h03, 0, 0);
        chk("pend_set", 16'(cfg_pend), 16'd1);
        step(0, 0, 0, 0, 1, 0);
        chk("no_commit_without_c3", 16'(hpix_beg), 16'd140);
        step(0, 0, 0, 0, 1, 1);
        chk("win_hb", 16'(hpix_beg), 16'd88);
        chk("win_ve", 16'(vpix_end), 16'd320);
        step(0, 0, 0, 0, 0, 0);
        // 60Hz switch forces nogfx for two commits
        step(0, 1, 0, 8'h04, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        chk("settle_60hz", 16'(cfg_60hz), 16'd1);
        chk("settle_nogfx0", 16'(nogfx), 16'd1);
        step(0, 0, 0, 0, 1, 1);
        chk("settle_nogfx1", 16'(nogfx), 16'd1);
        step(0, 0, 0, 0, 1, 1);
        chk("settle_done", 16'(nogfx), 16'd0);
        // write on the exact commit clock is deferred
        step(0, 1, 0, 8'h05, 1, 1);
        chk("same_clk_old", 16'(hpix_beg), 16'd140);
        chk("same_clk_pend", 16'(cfg_pend), 16'd1);
        step(0, 0, 0, 0, 1, 1);
        chk("same_clk_applied", 16'(hpix_beg), 16'd108);
        // Y-scroll back-to-back writes
        step(0, 1, 2, 8'h10, 0, 0);
        chk("yoffs_pulse0", 16'(y_offs_wr), 16'd1);
        step(0, 1, 3, 8'h01, 0, 0);
        chk("yoffs_pulse1", 16'(y_offs_wr), 16'd1);
        chk("rstart", 16'(rstart), 16'h110);
        step(0, 0, 0, 0, 0, 0);
        chk("yoffs_low", 16'(y_offs_wr), 16'd0);
        // reset during settle
        step(0, 1, 0, 8'h00, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        chk("in_settle", 16'(nogfx), 16'd1);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_settle_nogfx", 16'(nogfx), 16'd0);
        chk("rst_settle_60hz", 16'(cfg_60hz), 16'd0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 3, 3'($urandom_range(0, 7)),
                 8'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
